// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/LS memory port arbiter: FSM state
// encodings, requester IDs and the latency counter width.
package mem_arb_pkg;

    // Latency counter width; bounds MEM_LAT to 1..15.
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between the fetch (IF) and load/store (LS)
// requesters. ROUND_ROBIN=0 gives LS fixed priority on a tie; ROUND_ROBIN=1
// gives the tie to whichever requester was not granted last (rr_ptr_i).
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic   if_req_i,
    input  logic   ls_req_i,
    input  owner_e rr_ptr_i,
    output owner_e winner_o,
    output logic   valid_o
);

    // Pick a winner; a single requester always wins, ties follow the mode.
    always_comb begin
        valid_o  = if_req_i | ls_req_i;
        winner_o = OWN_LS;
        if (if_req_i && ls_req_i) begin
            if (ROUND_ROBIN) begin
                winner_o = (rr_ptr_i == OWN_IF) ? OWN_LS : OWN_IF;
            end else begin
                winner_o = OWN_LS;
            end
        end else if (if_req_i) begin
            winner_o = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction fetch (IF) and
// load/store (LS) requesters. One transaction at a time:
// IDLE -> ISSUE -> WAIT* -> CAPTURE -> RESP -> IDLE, all outputs registered.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: ties alternate between requesters
// instead of LS always winning.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > (2 ** CNT_W) - 1) begin : g_lat_check
            $error("mem_port_arbiter: MEM_LAT must be in 1..15");
        end
    endgenerate

    state_e             state_q;
    owner_e             owner_q;
    logic               we_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               if_gnt_q;
    logic               ls_gnt_q;
    logic               if_rvalid_q;
    logic               ls_rvalid_q;
    logic [DW-1:0]      if_rdata_q;
    logic [DW-1:0]      ls_rdata_q;
    logic               mem_en_q;
    logic               mem_we_q;
    logic [AW-1:0]      mem_addr_q;
    logic [DW-1:0]      mem_wdata_q;

    owner_e             rr_ptr;
    owner_e             pick_winner;
    logic               pick_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_MODE = 1'b1;
    owner_e rr_q;

    // Remember the last granted requester; reset behaves as if IF went last.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= OWN_IF;
        end else if (state_q == IDLE && pick_valid) begin
            rr_q <= pick_winner;
        end
    end

    assign rr_ptr = rr_q;
`else
    localparam bit RR_MODE = 1'b0;
    assign rr_ptr = OWN_IF;
`endif

    arb_pick #(
        .ROUND_ROBIN (RR_MODE)
    ) u_pick (
        .if_req_i (if_req),
        .ls_req_i (ls_req),
        .rr_ptr_i (rr_ptr),
        .winner_o (pick_winner),
        .valid_o  (pick_valid)
    );

    // Transaction FSM; every output is set on the edge entering its cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            if_gnt_q    <= 1'b0;
            ls_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // Strobes are single-cycle; address/data only shown during ISSUE.
            if_gnt_q    <= 1'b0;
            ls_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;

            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        owner_q  <= pick_winner;
                        mem_en_q <= 1'b1;
                        state_q  <= ISSUE;
                        if (pick_winner == OWN_LS) begin
                            ls_gnt_q    <= 1'b1;
                            we_q        <= ls_we;
                            mem_we_q    <= ls_we;
                            mem_addr_q  <= ls_addr;
                            mem_wdata_q <= ls_we ? ls_wdata : '0;
                        end else begin
                            if_gnt_q   <= 1'b1;
                            we_q       <= 1'b0;
                            mem_addr_q <= if_addr;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q   <= CNT_W'(MEM_LAT - 1);
                    state_q <= (MEM_LAT == 1) ? CAPTURE : WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state_q <= RESP;
                    if (owner_q == OWN_LS) begin
                        ls_rdata_q  <= we_q ? '0 : mem_rdata;
                        ls_rvalid_q <= 1'b1;
                    end else begin
                        if_rdata_q  <= mem_rdata;
                        if_rvalid_q <= 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_gnt    = if_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_gnt    = ls_gnt_q;
    assign ls_rvalid = ls_rvalid_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-timeline model schedules the
// expected outputs of every cycle from the arbitration and latency rules;
// a compare process checks the DUT each cycle; directed cases pin literals.
// Honours MEM_ARB_ROUND_ROBIN_EN for the tie rule.
module tb_mem_port_arbiter;

    localparam int TB_LAT = 2;
    localparam int NCYC   = 8192;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW      (32),
        .DW      (32),
        .MEM_LAT (TB_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Expected events for one cycle.
    typedef struct {
        bit          if_gnt, ls_gnt, mem_en, mem_we, if_rv, ls_rv;
        bit          if_rd_set, ls_rd_set, md_set;
        logic [31:0] mem_addr, mem_wdata, if_rd_val, ls_rd_val, md_val;
    } slot_t;

    slot_t       sched [NCYC];
    logic [31:0] mem_model [logic [31:0]];
    int          cyc;
    int          checks;
    int          errors;
    bit          chk_en;
    bit          hold;
    int          free_k;
    bit          last_ls;
    int          if_gnt_cyc;
    int          ls_gnt_cyc;
    logic [31:0] exp_if_rd;
    logic [31:0] exp_ls_rd;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, got, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", nm, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (!mem_model.exists(a)) mem_model[a] = $urandom;
        return mem_model[a];
    endfunction

    // Decide what the edge ending the current cycle does and schedule outputs.
    task automatic model_eval();
        int          k;
        bit          win_ls;
        bit          st;
        logic [31:0] a;
        logic [31:0] d;
        k = cyc;
        if (reset) begin
            for (int c = k + 1; c <= k + 20; c++) sched[c] = '{default: '0};
            sched[k+1].if_rd_set = 1'b1;
            sched[k+1].ls_rd_set = 1'b1;
            free_k  = k + 1;
            last_ls = 1'b0;
            if_gnt_cyc = -1;
            ls_gnt_cyc = -1;
        end else if (k >= free_k && (if_req || ls_req)) begin
            if (if_req && ls_req) win_ls = RR ? !last_ls : 1'b1;
            else                  win_ls = ls_req;
            st = win_ls && ls_we;
            a  = win_ls ? ls_addr : if_addr;
            if (st) begin
                mem_model[a] = ls_wdata;
                d = 32'h0;
            end else begin
                d = mem_read(a);
            end
            sched[k+1].mem_en   = 1'b1;
            sched[k+1].mem_addr = a;
            if (win_ls) begin
                sched[k+1].ls_gnt = 1'b1;
                ls_gnt_cyc = k + 1;
                if (st) begin
                    sched[k+1].mem_we    = 1'b1;
                    sched[k+1].mem_wdata = ls_wdata;
                end
                sched[k+2+TB_LAT].ls_rv     = 1'b1;
                sched[k+2+TB_LAT].ls_rd_set = 1'b1;
                sched[k+2+TB_LAT].ls_rd_val = d;
            end else begin
                sched[k+1].if_gnt = 1'b1;
                if_gnt_cyc = k + 1;
                sched[k+2+TB_LAT].if_rv     = 1'b1;
                sched[k+2+TB_LAT].if_rd_set = 1'b1;
                sched[k+2+TB_LAT].if_rd_val = d;
            end
            sched[k+1+TB_LAT].md_set = 1'b1;
            sched[k+1+TB_LAT].md_val = st ? $urandom : d;
            free_k  = k + 3 + TB_LAT;
            last_ls = win_ls;
        end
    endtask

    task automatic run_cycle();
        model_eval();
        @(posedge clk);
        #1;
        cyc++;
        mem_rdata = sched[cyc].md_set ? sched[cyc].md_val : $urandom;
        if (!hold && if_gnt_cyc == cyc) if_req = 1'b0;
        if (!hold && ls_gnt_cyc == cyc) ls_req = 1'b0;
    endtask

    task automatic go(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    // Per-cycle comparison of every DUT output against the model schedule.
    always begin
        @(posedge clk);
        #2;
        if (chk_en) begin
            if (sched[cyc].if_rd_set) exp_if_rd = sched[cyc].if_rd_val;
            if (sched[cyc].ls_rd_set) exp_ls_rd = sched[cyc].ls_rd_val;
            chk1("if_gnt", if_gnt, sched[cyc].if_gnt);
            chk1("ls_gnt", ls_gnt, sched[cyc].ls_gnt);
            chk1("if_rvalid", if_rvalid, sched[cyc].if_rv);
            chk1("ls_rvalid", ls_rvalid, sched[cyc].ls_rv);
            chk1("mem_en", mem_en, sched[cyc].mem_en);
            chk1("mem_we", mem_we, sched[cyc].mem_we);
            chk("mem_addr", mem_addr, sched[cyc].mem_addr);
            chk("mem_wdata", mem_wdata, sched[cyc].mem_wdata);
            chk("if_rdata", if_rdata, exp_if_rd);
            chk("ls_rdata", ls_rdata, exp_ls_rd);
            if (sched[cyc].if_rv) $display("txn cycle=%0d IF  rdata=%h", cyc, exp_if_rd);
            if (sched[cyc].ls_rv) $display("txn cycle=%0d LS  rdata=%h", cyc, exp_ls_rd);
        end
    end

    initial begin
        for (int c = 0; c < NCYC; c++) sched[c] = '{default: '0};
        cyc = 0; checks = 0; errors = 0; chk_en = 1'b0; hold = 1'b0;
        free_k = 0; last_ls = 1'b0; if_gnt_cyc = -1; ls_gnt_cyc = -1;
        exp_if_rd = 32'h0; exp_ls_rd = 32'h0;
        reset = 1'b1; if_req = 1'b0; if_addr = 32'h0; ls_req = 1'b0;
        ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0; mem_rdata = 32'h0;

        run_cycle();
        chk_en = 1'b1;
        chk("reset_outputs", 32'({if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we}), 32'h0);
        chk("reset_if_rdata", if_rdata, 32'h0);
        go(2);
        reset = 1'b0;
        go(1);

        // Fetch from 0x10.
        mem_model[32'h10] = 32'hDEADBEEF;
        if_req = 1'b1; if_addr = 32'h10;
        go(1);
        chk1("fetch_gnt", if_gnt, 1'b1);
        chk1("fetch_mem_en", mem_en, 1'b1);
        chk("fetch_mem_addr", mem_addr, 32'h10);
        go(1 + TB_LAT);
        chk1("fetch_rvalid", if_rvalid, 1'b1);
        chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
        chk1("fetch_ls_rvalid", ls_rvalid, 1'b0);
        go(2);

        // Store then load at 0x20.
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = 32'h12345678;
        go(1);
        chk1("store_gnt", ls_gnt, 1'b1);
        chk1("store_mem_we", mem_we, 1'b1);
        chk("store_wdata", mem_wdata, 32'h12345678);
        go(1);
        chk1("store_we_drop", mem_we, 1'b0);
        go(TB_LAT);
        chk1("store_rvalid", ls_rvalid, 1'b1);
        chk("store_rdata", ls_rdata, 32'h0);
        go(2);
        ls_req = 1'b1; ls_we = 1'b0;
        go(2 + TB_LAT);
        chk1("load_rvalid", ls_rvalid, 1'b1);
        chk("load_rdata", ls_rdata, 32'h12345678);
        go(2);

        // Tie straight after reset: LS first, IF at 4+MEM_LAT.
        reset = 1'b1;
        go(1);
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20;
        go(1);
        chk1("tie_ls_gnt", ls_gnt, 1'b1);
        chk1("tie_if_gnt_low", if_gnt, 1'b0);
        go(3 + TB_LAT);
        chk1("tie_if_gnt", if_gnt, 1'b1);
        go(2 + TB_LAT);

        // Reset while a load waits on memory.
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20;
        go(2);
        reset = 1'b1;
        go(1);
        reset = 1'b0;
        chk("midrst_outputs", 32'({if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we}), 32'h0);
        chk("midrst_ls_rdata", ls_rdata, 32'h0);
        go(TB_LAT + 3);
        if_req = 1'b1; if_addr = 32'h10;
        go(1);
        chk1("post_rst_gnt", if_gnt, 1'b1);
        go(1 + TB_LAT);
        chk("post_rst_rdata", if_rdata, 32'hDEADBEEF);
        go(2);

        // Both requesters held continuously.
        hold = 1'b1;
        if_req = 1'b1; if_addr = 32'h14;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h24;
        go(40);
        hold = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        go(20);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if (!if_req && cyc != if_gnt_cyc && $urandom_range(0, 3) == 0) begin
                if_req  = 1'b1;
                if_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (!ls_req && cyc != ls_gnt_cyc && $urandom_range(0, 3) == 0) begin
                ls_req   = 1'b1;
                ls_we    = ($urandom_range(0, 1) == 1);
                ls_addr  = 32'($urandom_range(0, 15)) << 2;
                ls_wdata = $urandom;
            end
            reset = ($urandom_range(0, 149) == 0);
            run_cycle();
        end
        reset = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        go(25);

        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
